// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - retire record layout, kind encoding and record helpers
package trace_pkg;

  localparam int REC_W = 71;

  // Field offsets within {pc16, regwrite, wreg3, wdata16, memread, memwrite, maddr16, mdata16, halt}
  localparam int OFF_HALT     = 0;
  localparam int OFF_MDATA    = 1;
  localparam int OFF_MADDR    = 17;
  localparam int OFF_MEMWRITE = 33;
  localparam int OFF_MEMREAD  = 34;
  localparam int OFF_WDATA    = 35;
  localparam int OFF_WREG     = 51;
  localparam int OFF_REGWRITE = 54;
  localparam int OFF_PC       = 55;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_ST   = 3'd1,
    KIND_REG  = 3'd2,
    KIND_LD   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  function automatic kind_e classify(input logic [REC_W-1:0] rec);
    kind_e k;
    if (rec[OFF_HALT])                             k = KIND_HALT;
    else if (rec[OFF_REGWRITE] && rec[OFF_MEMWRITE]) k = KIND_STU;
    else if (rec[OFF_REGWRITE] && rec[OFF_MEMREAD])  k = KIND_LD;
    else if (rec[OFF_REGWRITE])                    k = KIND_REG;
    else if (rec[OFF_MEMWRITE])                    k = KIND_ST;
    else                                           k = KIND_NOP;
    return k;
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [15:0] pc,
    input logic        regwrite,
    input logic [2:0]  wreg,
    input logic [15:0] wdata,
    input logic        memread,
    input logic        memwrite,
    input logic [15:0] maddr,
    input logic [15:0] mdata,
    input logic        halt
  );
    logic [REC_W-1:0] r;
    r                  = '0;
    r[OFF_PC +: 16]    = pc;
    r[OFF_REGWRITE]    = regwrite;
    r[OFF_WREG +: 3]   = wreg;
    r[OFF_WDATA +: 16] = wdata;
    r[OFF_MEMREAD]     = memread;
    r[OFF_MEMWRITE]    = memwrite;
    r[OFF_MADDR +: 16] = maddr;
    r[OFF_MDATA +: 16] = mdata;
    r[OFF_HALT]        = halt;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through record FIFO, up to LANES compacted writes and one read per cycle
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int LANES = 1,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [LANES-1:0]         i_wr_en,
  input  logic [LANES*W-1:0]       i_wr_data,
  input  logic                     i_rd_en,
  output logic                     o_valid,
  output logic [W-1:0]             o_rd_data,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic [AW:0]   w_n_wr;

  assign o_valid   = (r_count != '0);
  assign w_pop     = i_rd_en & o_valid;
  // Free space comes from registered occupancy only, so a pop never frees a slot for the same edge
  assign o_free    = (AW+1)'(DEPTH) - r_count;
  assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;

  always_comb begin
    w_n_wr = '0;
    for (int s = 0; s < LANES; s++) begin
      if (i_wr_en[s]) w_n_wr = w_n_wr + (AW+1)'(1);
    end
  end

  // Writes arrive compacted from slot 0, so slot s lands at wr_ptr + s
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < LANES; s++) begin
      if (i_wr_en[s]) r_mem[r_wr_ptr + AW'(s)] <= i_wr_data[s*W +: W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_wr[AW-1:0];
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count + w_n_wr - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - classifies retired instructions, numbers them and queues trace records
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*REC_W-1:0] in_rec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REC_W-1:0]       out_rec,
  output logic [2:0]             out_kind,
  output logic [CNT_W-1:0]       out_inum,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       inst_count,
  output logic                   halted,
  output logic                   done,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int EW = CNT_W + 3 + REC_W;
  localparam int FW = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]   r_cycle;
  logic [CNT_W-1:0]   r_inst;
  logic               r_halted;
  logic               r_overflow;
  logic [15:0]        r_drop;

  logic [FW-1:0]      w_free;
  logic [LANES-1:0]   w_wr_en;
  logic [LANES*EW-1:0] w_wr_data;
  logic [1:0]         w_consumed;
  logic [1:0]         w_enq;
  logic [1:0]         w_dropped;
  logic               w_halt_seen;
  logic [REC_W-1:0]   w_lane_rec;
  logic [EW-1:0]      w_entry;
  logic [EW-1:0]      w_head;
  logic [16:0]        w_drop_sum;

  // Walk lanes oldest first: each live lane takes the next inum, then either a FIFO slot or a drop.
  // A halt stops the walk, so younger lanes in that cycle are neither numbered nor counted.
  always_comb begin
    w_wr_en     = '0;
    w_wr_data   = '0;
    w_consumed  = '0;
    w_enq       = '0;
    w_dropped   = '0;
    w_halt_seen = 1'b0;
    w_lane_rec  = '0;
    w_entry     = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_valid[l] && !r_halted && !w_halt_seen) begin
        w_lane_rec = in_rec[l*REC_W +: REC_W];
        w_entry    = {r_inst + CNT_W'(w_consumed), classify(w_lane_rec), w_lane_rec};
        if (FW'(w_enq) < w_free) begin
          for (int s = 0; s < LANES; s++) begin
            if (s == int'(w_enq)) begin
              w_wr_en[s]             = 1'b1;
              w_wr_data[s*EW +: EW]  = w_entry;
            end
          end
          w_enq = w_enq + 2'd1;
        end else begin
          w_dropped = w_dropped + 2'd1;
        end
        w_consumed = w_consumed + 2'd1;
        if (w_lane_rec[OFF_HALT]) w_halt_seen = 1'b1;
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_dropped);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle    <= '0;
      r_inst     <= '0;
      r_halted   <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (!r_halted) begin
        r_cycle <= r_cycle + CNT_W'(1);
        r_inst  <= r_inst + CNT_W'(w_consumed);
      end
      if (w_halt_seen) r_halted <= 1'b1;
      if (w_dropped != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .W     (EW)
  ) u_fifo (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (out_ready),
    .o_valid   (out_valid),
    .o_rd_data (w_head),
    .o_free    (w_free)
  );

  assign out_inum    = w_head[EW-1 -: CNT_W];
  assign out_kind    = w_head[REC_W +: 3];
  assign out_rec     = w_head[REC_W-1:0];
  assign cycle_count = r_cycle;
  assign inst_count  = r_inst;
  assign halted      = r_halted;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop;
  assign done        = r_halted & ~out_valid;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed bench for a 1-lane/depth-8 and a 2-lane/depth-4 trace buffer
module tb_retire_trace_buffer;
  import trace_pkg::*;

  logic clk;
  logic rst;

  logic [0:0]         v1;
  logic [REC_W-1:0]   rec1;
  logic               rdy1;
  logic               ov1, halt1, done1, ovf1;
  logic [REC_W-1:0]   orec1;
  logic [2:0]         okind1;
  logic [31:0]        oinum1, cyc1, inst1;
  logic [15:0]        drop1;

  logic [1:0]         v2;
  logic [2*REC_W-1:0] rec2;
  logic               rdy2;
  logic               ov2, halt2, done2, ovf2;
  logic [REC_W-1:0]   orec2;
  logic [2:0]         okind2;
  logic [31:0]        oinum2, cyc2, inst2;
  logic [15:0]        drop2;

  int n_chk;
  int n_err;
  int e_cyc1;
  int e_cyc2;
  bit e_halt2;

  logic [REC_W-1:0] ktab_rec [7];
  logic [2:0]       ktab_kind [7];
  logic [REC_W-1:0] halt_rec;

  retire_trace_buffer #(.LANES(1), .DEPTH(8), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_rec(rec1),
    .out_valid(ov1), .out_ready(rdy1), .out_rec(orec1), .out_kind(okind1), .out_inum(oinum1),
    .cycle_count(cyc1), .inst_count(inst1), .halted(halt1), .done(done1),
    .overflow(ovf1), .drop_count(drop1)
  );

  retire_trace_buffer #(.LANES(2), .DEPTH(4), .CNT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_rec(rec2),
    .out_valid(ov2), .out_ready(rdy2), .out_rec(orec2), .out_kind(okind2), .out_inum(oinum2),
    .cycle_count(cyc2), .inst_count(inst2), .halted(halt2), .done(done2),
    .overflow(ovf2), .drop_count(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [REC_W-1:0] reg_rec(input logic [15:0] pc);
    return pack_rec(pc, 1'b1, 3'd1, pc ^ 16'h5A5A, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      e_cyc1++;
      if (!e_halt2) e_cyc2++;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; e_cyc1 = 0; e_cyc2 = 0; e_halt2 = 1'b0;
    rst = 1'b0;
    v1 = '0; rec1 = '0; rdy1 = 1'b0;
    v2 = '0; rec2 = '0; rdy2 = 1'b0;

    ktab_rec[0] = pack_rec(16'h0010, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0); ktab_kind[0] = 3'd0;
    ktab_rec[1] = pack_rec(16'h0011, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0080, 16'hBEEF, 1'b0); ktab_kind[1] = 3'd1;
    ktab_rec[2] = pack_rec(16'h0012, 1'b1, 3'd3, 16'h0007, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0); ktab_kind[2] = 3'd2;
    ktab_rec[3] = pack_rec(16'h0013, 1'b1, 3'd4, 16'h0009, 1'b1, 1'b0, 16'h0084, 16'h0000, 1'b0); ktab_kind[3] = 3'd3;
    ktab_rec[4] = pack_rec(16'h0014, 1'b1, 3'd5, 16'h000A, 1'b0, 1'b1, 16'h0088, 16'h0001, 1'b0); ktab_kind[4] = 3'd4;
    ktab_rec[5] = pack_rec(16'h0015, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h008C, 16'h0000, 1'b0); ktab_kind[5] = 3'd0;
    ktab_rec[6] = pack_rec(16'h0016, 1'b1, 3'd6, 16'h000B, 1'b1, 1'b1, 16'h0090, 16'h0002, 1'b0); ktab_kind[6] = 3'd4;
    halt_rec    = pack_rec(16'h0500, 1'b1, 3'd2, 16'h1234, 1'b0, 1'b1, 16'h0040, 16'h5678, 1'b1);

    // Reset state before any edge
    #2;
    chk("rst_valid", ov1, 0);
    chk("rst_cycle", cyc1, 0);
    chk("rst_inst", inst1, 0);
    chk("rst_halted", halt1, 0);
    chk("rst_overflow", ovf1, 0);
    chk("rst_drop", drop1, 0);
    chk("rst_rec", orec1, 0);
    chk("rst_kind", okind1, 0);
    chk("rst_inum", oinum1, 0);
    chk("rst_done", done1, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Three REG retires streamed through a single-lane buffer
    rdy1 = 1'b1; v1 = 1'b1; rec1 = reg_rec(16'h0100);
    chk("A_fwft", ov1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("A_valid", ov1, 1);
      chk("A_inum", oinum1, 80'(i));
      chk("A_kind", okind1, 2);
      chk("A_rec", orec1, reg_rec(16'(16'h0100 + i)));
      rec1 = reg_rec(16'(16'h0101 + i));
      if (i == 2) v1 = 1'b0;
    end
    step();
    chk("A_empty", ov1, 0);
    chk("A_inst", inst1, 3);
    chk("A_cycle", cyc1, 80'(e_cyc1));

    // Dual-lane overflow: 6 retires into 4 slots with a stalled consumer
    rdy2 = 1'b0; v2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rec2 = {reg_rec(16'(16'h0201 + 2*i)), reg_rec(16'(16'h0200 + 2*i))};
      step();
      chk("B_drop_i", drop2, (i == 2) ? 2 : 0);
      chk("B_ovf_i", ovf2, (i == 2) ? 1 : 0);
    end
    v2 = 2'b00;
    chk("B_valid", ov2, 1);
    chk("B_inum", oinum2, 0);
    chk("B_rec", orec2, reg_rec(16'h0200));
    chk("B_inst", inst2, 6);
    step();
    chk("B_hold_inum", oinum2, 0);
    chk("B_hold_rec", orec2, reg_rec(16'h0200));

    // Full FIFO: same-cycle push is dropped while the pop goes through
    rdy2 = 1'b1; v2 = 2'b01; rec2 = {{REC_W{1'b0}}, reg_rec(16'h0300)};
    step();
    v2 = 2'b00;
    chk("C_inum", oinum2, 1);
    chk("C_drop", drop2, 3);
    chk("C_inst", inst2, 7);
    step();
    chk("C_inum2", oinum2, 2);
    step();
    chk("C_inum3", oinum2, 3);
    step();
    chk("C_empty", ov2, 0);

    // Lane-1-only retire is compacted into a single record
    rdy2 = 1'b0; v2 = 2'b10; rec2 = {reg_rec(16'h0400), reg_rec(16'h04FF)};
    step();
    v2 = 2'b00;
    chk("L1_valid", ov2, 1);
    chk("L1_inum", oinum2, 7);
    chk("L1_rec", orec2, reg_rec(16'h0400));
    chk("L1_inst", inst2, 8);
    rdy2 = 1'b1;
    step();
    chk("L1_empty", ov2, 0);

    // Kind priority table on the single-lane buffer
    rdy1 = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rec1 = ktab_rec[k];
      step();
    end
    v1 = 1'b0;
    rdy1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("K_kind", okind1, 80'(ktab_kind[k]));
      chk("K_inum", oinum1, 80'(3 + k));
      chk("K_rec", orec1, 80'(ktab_rec[k]));
      step();
    end
    chk("K_empty", ov1, 0);

    // Asynchronous reset with three records queued
    rdy1 = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rec1 = reg_rec(16'(16'h0700 + k));
      step();
    end
    v1 = 1'b0;
    chk("R_queued", ov1, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("R_valid", ov1, 0);
    chk("R_cycle", cyc1, 0);
    chk("R_inst", inst1, 0);
    chk("R_rec", orec1, 0);
    chk("R_inum", oinum1, 0);
    chk("R_drop2", drop2, 0);
    chk("R_ovf2", ovf2, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    e_cyc1 = 0; e_cyc2 = 0;
    step();
    chk("R_cycle1", cyc1, 1);
    chk("R_nopop", ov1, 0);

    // Halt in lane 0 with a REG in lane 1, then ignored input after halting
    rdy2 = 1'b0; v2 = 2'b11; rec2 = {reg_rec(16'h0600), halt_rec};
    chk("H_done0", done2, 0);
    step();
    e_halt2 = 1'b1;
    chk("H_valid", ov2, 1);
    chk("H_kind", okind2, 5);
    chk("H_inum", oinum2, 0);
    chk("H_rec", orec2, halt_rec);
    chk("H_inst", inst2, 1);
    chk("H_halted", halt2, 1);
    chk("H_done", done2, 0);
    chk("H_cycle", cyc2, 80'(e_cyc2));
    step();
    chk("H_inst_frz", inst2, 1);
    chk("H_cycle_frz", cyc2, 80'(e_cyc2));
    chk("H_head", oinum2, 0);
    v2 = 2'b00; rdy2 = 1'b1;
    step();
    chk("H_empty", ov2, 0);
    chk("H_done1", done2, 1);
    chk("H_halted1", halt2, 1);
    chk("H_cyc1_run", cyc1, 80'(e_cyc1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning retire lanes per cycle (legal values 1 or 2; lane 0 is the older lane).
REQ-002 SHALL have parameter DEPTH, default 8, meaning record FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the cycle, instruction and inum counters.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, LANES bits: per-lane retire strobe.
REQ-007 SHALL have port in_rec, input, LANES*REC_W bits: per-lane retire record {pc16, regwrite, wreg3, wdata16, memread, memwrite, maddr16, mdata16, halt}; lane 0 sits in the LSBs.
REQ-008 SHALL have port out_valid, output, 1 bit: head record available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the head record.
REQ-010 SHALL have port out_rec, output, REC_W bits: head record.
REQ-011 SHALL have port out_kind, output, 3 bits: head record kind.
REQ-012 SHALL have port out_inum, output, CNT_W bits: head record instruction number.
REQ-013 SHALL have port cycle_count, output, CNT_W bits: cycles since reset.
REQ-014 SHALL have port inst_count, output, CNT_W bits: retired instructions.
REQ-015 SHALL have port halted, output, 1 bit: a halt has retired.
REQ-016 SHALL have port done, output, 1 bit: halted and FIFO empty.
REQ-017 SHALL have port overflow, output, 1 bit: sticky, records have been dropped.
REQ-018 SHALL have port drop_count, output, 16 bits: dropped records, saturating.

Function
REQ-019 Kind SHALL be assigned by priority: HALT(5) if halt; STU(4) if regwrite&memwrite; LD(3) if regwrite&memread; REG(2) if regwrite; ST(1) if memwrite; NOP(0) otherwise.
REQ-020 Each valid lane SHALL consume one inum, in lane order, starting at 0 after reset; inst_count SHALL equal the number of inums consumed.
REQ-021 Valid lanes SHALL be compacted: lane1-only retire behaves as a single record.
REQ-022 A record accepted in cycle N SHALL appear at the FIFO head no earlier than cycle N+1 (FIFO is first-word-fall-through from registered storage).
REQ-023 Free slots SHALL be DEPTH minus the registered occupancy; a same-cycle pop SHALL NOT create room for a same-cycle push.
REQ-024 When valid lanes exceed free slots, older lanes SHALL be enqueued first and the rest dropped; each dropped record SHALL still consume its inum, SHALL increment drop_count (saturating at 0xFFFF), and SHALL set overflow.
REQ-025 The head record SHALL pop when out_valid&out_ready; out_rec, out_kind and out_inum SHALL be stable while out_valid&!out_ready.
REQ-026 A retired halt, whether enqueued or dropped, SHALL set halted on the next edge; lanes younger than the halt lane in the same cycle SHALL be ignored and not counted.
REQ-027 Once halted, in_valid SHALL be ignored, inst_count and cycle_count SHALL freeze, and draining SHALL continue normally.
REQ-028 cycle_count SHALL increment every cycle while rst is high and halted is low, wrapping modulo 2^CNT_W; inum and inst_count SHALL wrap likewise.
REQ-029 done SHALL equal halted & !out_valid.

Reset
REQ-030 While rst is low, asynchronously: FIFO empty, out_valid=0, all counters 0, halted=0, overflow=0, drop_count=0; out_rec, out_kind and out_inum SHALL read 0.
REQ-031 Reset asserted mid-drain SHALL discard all records, with no partial pop.
REQ-032 After rst deasserts, the first edge SHALL count as cycle 0→1.

Structure
REQ-033 Package trace_pkg SHALL hold REC_W (71), the field offsets, and the kind enum.
REQ-034 Storage SHALL be a sub-module trace_fifo (DEPTH entries, up to LANES writes and 1 read per cycle); classification, counters and halt logic SHALL reside in the top level.

Verification
REQ-035 LANES=1, three REG retires with out_ready=1 → inums 0,1,2, kind 2 each; inst_count=3.
REQ-036 LANES=2, DEPTH=4, out_ready=0, 3 cycles of both lanes valid → 4 stored (inum 0-3); inums 4,5 dropped; drop_count=2; overflow=1.
REQ-037 LANES=2, lane0 HALT and lane1 REG in the same cycle → one record kind 5; inst_count=1; halted=1; done=1 after it pops.
REQ-038 Full FIFO, push and pop in the same cycle → push dropped, pop succeeds, occupancy = DEPTH-1.
REQ-039 rst pulsed low with 3 records queued → out_valid=0 and counters 0 immediately, without waiting for a clock edge.
REQ-040 A retire with regwrite, memwrite and halt all set → kind 5 (halt priority).
